// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
//   ID/EX pipeline register with stall, flush and a debug halt/single-step FSM.
//   The control word, operand buses, immediate, register specifiers and PC+4
//   are captured from ID and presented to EX one cycle later. While the debug
//   FSM is halted, bubbles are fed to EX and upstream stages are frozen through
//   o_stall_req.
//
//   Optional feature (macro ID_EX_BUBBLE_CNT_EN):
//     defined   -> o_bubble_cnt counts bubble-loading edges, saturating,
//                  cleared by i_cnt_clr (clear beats increment)
//     undefined -> o_bubble_cnt is tied to 0 and i_cnt_clr is ignored
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_ctrl_register           20-bit control word from the ID control generator
//   i_valid                   ID holds a real instruction
//   i_bus_a, i_bus_b          register file read data
//   i_inm                     raw immediate
//   i_rs/i_rt/i_rd/i_shamt    instruction register fields
//   i_funct                   function code
//   i_pc_next                 PC+4 of the ID instruction
//   i_stall, i_flush          hazard-unit hold / bubble-insert requests
//   i_halt, i_step            debug halt level / single-step pulse
//   i_cnt_clr                 bubble counter clear
//   o_*                       registered copies presented to EX
//   o_halted                  debug FSM is not in RUN
//   o_stall_req               freeze PC and IF/ID (FSM in HALTED)
//   o_bubble_cnt              bubble count
// -----------------------------------------------------------------------------
module id_ex_reg #(
    parameter int NB_DATA = 32,
    parameter int NB_CTRL = 20,
    parameter int NB_INM  = 16,
    parameter int NB_REG  = 5,
    parameter int NB_CNT  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_CTRL-1:0] i_ctrl_register,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_bus_a,
    input  logic [NB_DATA-1:0] i_bus_b,
    input  logic [NB_INM-1:0]  i_inm,
    input  logic [NB_REG-1:0]  i_rs,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic [NB_REG-1:0]  i_shamt,
    input  logic [5:0]         i_funct,
    input  logic [NB_DATA-1:0] i_pc_next,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_halt,
    input  logic               i_step,
    input  logic               i_cnt_clr,
    output logic [NB_CTRL-1:0] o_ctrl_register,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_bus_a,
    output logic [NB_DATA-1:0] o_bus_b,
    output logic [NB_DATA-1:0] o_pc_next,
    output logic [NB_INM-1:0]  o_inm,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_rd,
    output logic [NB_REG-1:0]  o_shamt,
    output logic [5:0]         o_funct,
    output logic               o_halted,
    output logic               o_stall_req,
    output logic [NB_CNT-1:0]  o_bubble_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    // What the pipeline register does on the coming edge.
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_LOAD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } pipe_act_t;

    state_t    state, state_nxt;
    pipe_act_t pipe_act;

    // -------------------------------------------------------------------------
    // Next-state and pipeline action decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_nxt = state;
        pipe_act  = ACT_HOLD;

        // Pipeline action: HALTED always feeds bubbles; RUN and STEP share the
        // flush > stall > load priority, and a non-valid load is a bubble.
        if (state == ST_HALTED) begin
            pipe_act = ACT_BUBBLE;
        end else if (i_flush) begin
            pipe_act = ACT_BUBBLE;
        end else if (i_stall) begin
            pipe_act = ACT_HOLD;
        end else if (i_valid) begin
            pipe_act = ACT_LOAD;
        end else begin
            pipe_act = ACT_BUBBLE;
        end

        case (state)
            ST_RUN: begin
                if (i_halt) state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                // i_step only matters while the halt request is still held.
                if (!i_halt)     state_nxt = ST_RUN;
                else if (i_step) state_nxt = ST_STEP;
            end
            ST_STEP: begin
                // A held (stalled, unflushed) edge does not consume the step.
                if (!(i_stall && !i_flush)) begin
                    state_nxt = i_halt ? ST_HALTED : ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!i_rst_n) state <= ST_RUN;
        else          state <= state_nxt;
    end

    // Registered decodes of the state flops; no input reaches these outputs.
    assign o_halted    = (state != ST_RUN);
    assign o_stall_req = (state == ST_HALTED);

    // -------------------------------------------------------------------------
    // Pipeline register. A bubble clears only valid and the control word; the
    // data fields keep their previous contents.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ctrl_register <= '0;
            o_valid         <= 1'b0;
            o_bus_a         <= '0;
            o_bus_b         <= '0;
            o_pc_next       <= '0;
            o_inm           <= '0;
            o_rs            <= '0;
            o_rt            <= '0;
            o_rd            <= '0;
            o_shamt         <= '0;
            o_funct         <= '0;
        end else begin
            case (pipe_act)
                ACT_LOAD: begin
                    o_ctrl_register <= i_ctrl_register;
                    o_valid         <= 1'b1;
                    o_bus_a         <= i_bus_a;
                    o_bus_b         <= i_bus_b;
                    o_pc_next       <= i_pc_next;
                    o_inm           <= i_inm;
                    o_rs            <= i_rs;
                    o_rt            <= i_rt;
                    o_rd            <= i_rd;
                    o_shamt         <= i_shamt;
                    o_funct         <= i_funct;
                end
                ACT_BUBBLE: begin
                    o_ctrl_register <= '0;
                    o_valid         <= 1'b0;
                end
                default: ; // hold
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Bubble counter
    // -------------------------------------------------------------------------
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [NB_CNT-1:0] bubble_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bubble_cnt <= '0;
        end else if (i_cnt_clr) begin
            bubble_cnt <= '0;
        end else if (pipe_act == ACT_BUBBLE && bubble_cnt != {NB_CNT{1'b1}}) begin
            bubble_cnt <= bubble_cnt + {{(NB_CNT-1){1'b0}}, 1'b1};
        end
    end

    assign o_bubble_cnt = bubble_cnt;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = i_cnt_clr;
    assign o_bubble_cnt   = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg
//   Self-checking bench for id_ex_reg. A behavioural model tracks what EX must
//   see and a compare process checks every output on each falling edge; the
//   directed sequence adds hand-computed literal expectations.
//   The counter is instantiated 4 bits wide so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

    localparam int NB_DATA = 32;
    localparam int NB_CTRL = 20;
    localparam int NB_INM  = 16;
    localparam int NB_REG  = 5;
    localparam int NB_CNT  = 4;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic [NB_CTRL-1:0] i_ctrl_register;
    logic               i_valid;
    logic [NB_DATA-1:0] i_bus_a, i_bus_b, i_pc_next;
    logic [NB_INM-1:0]  i_inm;
    logic [NB_REG-1:0]  i_rs, i_rt, i_rd, i_shamt;
    logic [5:0]         i_funct;
    logic               i_stall, i_flush, i_halt, i_step, i_cnt_clr;

    logic [NB_CTRL-1:0] o_ctrl_register;
    logic               o_valid;
    logic [NB_DATA-1:0] o_bus_a, o_bus_b, o_pc_next;
    logic [NB_INM-1:0]  o_inm;
    logic [NB_REG-1:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [5:0]         o_funct;
    logic               o_halted, o_stall_req;
    logic [NB_CNT-1:0]  o_bubble_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_reg #(
        .NB_DATA(NB_DATA), .NB_CTRL(NB_CTRL), .NB_INM(NB_INM),
        .NB_REG(NB_REG), .NB_CNT(NB_CNT)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_ctrl_register(i_ctrl_register), .i_valid(i_valid),
        .i_bus_a(i_bus_a), .i_bus_b(i_bus_b), .i_inm(i_inm),
        .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt),
        .i_funct(i_funct), .i_pc_next(i_pc_next),
        .i_stall(i_stall), .i_flush(i_flush), .i_halt(i_halt),
        .i_step(i_step), .i_cnt_clr(i_cnt_clr),
        .o_ctrl_register(o_ctrl_register), .o_valid(o_valid),
        .o_bus_a(o_bus_a), .o_bus_b(o_bus_b), .o_pc_next(o_pc_next),
        .o_inm(o_inm), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_shamt(o_shamt), .o_funct(o_funct),
        .o_halted(o_halted), .o_stall_req(o_stall_req),
        .o_bubble_cnt(o_bubble_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: "what EX holds" plus the debug mode as two flags
    // (halted, and whether a single step has been granted).
    // -------------------------------------------------------------------------
    logic [NB_CTRL-1:0] m_ctrl;
    logic               m_valid;
    logic [NB_DATA-1:0] m_bus_a, m_bus_b, m_pc;
    logic [NB_INM-1:0]  m_inm;
    logic [NB_REG-1:0]  m_rs, m_rt, m_rd, m_shamt;
    logic [5:0]         m_funct;
    logic               m_halted, m_step_granted;
    logic [NB_CNT-1:0]  m_cnt;

    // 0 = hold, 1 = load, 2 = bubble
    function automatic int edge_action(input logic halted_frozen, input logic flush,
                                       input logic stall, input logic valid);
        if (halted_frozen || flush) return 2;
        if (stall)                  return 0;
        return valid ? 1 : 2;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_ctrl <= '0; m_valid <= 1'b0; m_bus_a <= '0; m_bus_b <= '0; m_pc <= '0;
            m_inm <= '0; m_rs <= '0; m_rt <= '0; m_rd <= '0; m_shamt <= '0; m_funct <= '0;
            m_halted <= 1'b0; m_step_granted <= 1'b0; m_cnt <= '0;
        end else begin
            case (edge_action(m_halted && !m_step_granted, i_flush, i_stall, i_valid))
                1: begin
                    m_ctrl <= i_ctrl_register; m_valid <= 1'b1;
                    m_bus_a <= i_bus_a; m_bus_b <= i_bus_b; m_pc <= i_pc_next;
                    m_inm <= i_inm; m_rs <= i_rs; m_rt <= i_rt; m_rd <= i_rd;
                    m_shamt <= i_shamt; m_funct <= i_funct;
                end
                2: begin
                    m_ctrl <= '0; m_valid <= 1'b0;
                end
                default: ;
            endcase

            if (!m_halted) begin
                m_halted <= i_halt;
            end else if (!m_step_granted) begin
                if (!i_halt)     m_halted <= 1'b0;
                else if (i_step) m_step_granted <= 1'b1;
            end else if (!(i_stall && !i_flush)) begin
                m_step_granted <= 1'b0;
                m_halted       <= i_halt;
            end

`ifdef ID_EX_BUBBLE_CNT_EN
            if (i_cnt_clr)
                m_cnt <= '0;
            else if (edge_action(m_halted && !m_step_granted, i_flush, i_stall, i_valid) == 2
                     && m_cnt != 4'hF)
                m_cnt <= m_cnt + 4'd1;
`endif
        end
    end

    // Compare process: every output, every falling edge.
    always @(negedge i_clk) begin
        check("ctrl",      64'(o_ctrl_register), 64'(m_ctrl));
        check("valid",     64'(o_valid),         64'(m_valid));
        check("bus_a",     64'(o_bus_a),         64'(m_bus_a));
        check("bus_b",     64'(o_bus_b),         64'(m_bus_b));
        check("pc_next",   64'(o_pc_next),       64'(m_pc));
        check("inm",       64'(o_inm),           64'(m_inm));
        check("rs",        64'(o_rs),            64'(m_rs));
        check("rt",        64'(o_rt),            64'(m_rt));
        check("rd",        64'(o_rd),            64'(m_rd));
        check("shamt",     64'(o_shamt),         64'(m_shamt));
        check("funct",     64'(o_funct),         64'(m_funct));
        check("halted",    64'(o_halted),        64'(m_halted));
        check("stall_req", 64'(o_stall_req),     64'(m_halted && !m_step_granted));
        check("bubble_cnt",64'(o_bubble_cnt),    64'(m_cnt));
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // -------------------------------------------------------------------------
    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [NB_CTRL-1:0] ctrl, input logic valid,
                         input logic [NB_DATA-1:0] bus_a);
        i_ctrl_register = ctrl;
        i_valid         = valid;
        i_bus_a         = bus_a;
        i_bus_b         = ~bus_a;
        i_pc_next       = bus_a + 32'd4;
        i_inm           = bus_a[15:0];
        i_rs            = bus_a[4:0];
        i_rt            = bus_a[9:5];
        i_rd            = bus_a[14:10];
        i_shamt         = bus_a[19:15];
        i_funct         = bus_a[25:20];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_valid, n_stall_req, n_halted;

        i_rst_n = 1'b0;
        i_stall = 0; i_flush = 0; i_halt = 0; i_step = 0; i_cnt_clr = 0;
        drive(20'h0, 1'b0, 32'h0);
        #2;
        // Reset state
        check("rst_ctrl",      64'(o_ctrl_register), 64'h0);
        check("rst_valid",     64'(o_valid),         64'h0);
        check("rst_bus_a",     64'(o_bus_a),         64'h0);
        check("rst_halted",    64'(o_halted),        64'h0);
        check("rst_stall_req", 64'(o_stall_req),     64'h0);
        check("rst_cnt",       64'(o_bubble_cnt),    64'h0);
        cycle(); cycle();
        i_rst_n = 1'b1;

        // Basic load, one-cycle latency
        drive(20'h0A5C3, 1'b1, 32'h1234_5678);
        cycle();
        check("load_ctrl",  64'(o_ctrl_register), 64'h0A5C3);
        check("load_bus_a", 64'(o_bus_a),         64'h1234_5678);
        check("load_valid", 64'(o_valid),         64'h1);
        check("load_pc",    64'(o_pc_next),       64'h1234_567C);

        // Stall holds A for three edges while inputs show B
        drive(20'h00003, 1'b1, 32'hAAAA_0001);
        cycle();
        drive(20'h1F0F0, 1'b1, 32'hBBBB_0002);
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_ctrl",  64'(o_ctrl_register), 64'h00003);
            check("stall_bus_a", 64'(o_bus_a),         64'hAAAA_0001);
        end
        i_stall = 1'b0;
        cycle();
        check("after_stall_ctrl",  64'(o_ctrl_register), 64'h1F0F0);
        check("after_stall_bus_a", 64'(o_bus_a),         64'hBBBB_0002);

        // Flush and stall together: flush wins, data holds
        drive(20'hFFFFF, 1'b1, 32'hCCCC_0003);
        i_stall = 1'b1; i_flush = 1'b1;
        cycle();
        check("flush_valid",     64'(o_valid),            64'h0);
        check("flush_ctrl",      64'(o_ctrl_register),    64'h0);
        check("flush_mem_write", 64'(o_ctrl_register[2]), 64'h0);
        check("flush_wb_en",     64'(o_ctrl_register[1]), 64'h0);
        check("flush_bus_a",     64'(o_bus_a),            64'hBBBB_0002);
        i_stall = 1'b0; i_flush = 1'b0;

        // Halt for ten edges with a single step at edge 4
        n_valid = 0; n_stall_req = 0; n_halted = 0;
        for (int k = 0; k <= 10; k++) begin
            i_halt = (k < 10);
            i_step = (k == 4);
            drive(20'h10000 | 20'(k), 1'b1, 32'hD000_0000 + 32'(k));
            cycle();
            if (k >= 1 && o_valid) n_valid++;
            if (k < 10) begin
                if (o_stall_req) n_stall_req++;
                if (o_halted)    n_halted++;
            end
            if (k == 5) check("step_ctrl", 64'(o_ctrl_register), 64'h10005);
        end
        i_step = 1'b0;
        check("halt_valid_count",     64'(n_valid),     64'd1);
        check("halt_stall_req_count", 64'(n_stall_req), 64'd9);
        check("halt_halted_count",    64'(n_halted),    64'd10);
        check("halt_released",        64'(o_halted),    64'h0);

        // Step granted while stalled: waits, then loads exactly once
        i_halt = 1'b1;
        drive(20'h20001, 1'b1, 32'hE000_0001);
        cycle();
        i_step = 1'b1; i_stall = 1'b1;
        cycle();
        i_step = 1'b0;
        check("step_enter_stall_req", 64'(o_stall_req), 64'h0);
        drive(20'h20002, 1'b1, 32'hE000_0002);
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("step_hold_halted",    64'(o_halted),    64'h1);
            check("step_hold_stall_req", 64'(o_stall_req), 64'h0);
            check("step_hold_valid",     64'(o_valid),     64'h0);
        end
        i_stall = 1'b0;
        cycle();
        check("step_load_valid",     64'(o_valid),         64'h1);
        check("step_load_ctrl",      64'(o_ctrl_register), 64'h20002);
        check("step_back_stall_req", 64'(o_stall_req),     64'h1);
        cycle();
        check("step_after_valid", 64'(o_valid), 64'h0);
        i_halt = 1'b0;
        cycle();
        check("step_run", 64'(o_halted), 64'h0);

        // Bubble counter: 5 flushes + 3 halted edges
        drive(20'h30001, 1'b1, 32'hF000_0001);
        i_cnt_clr = 1'b1;
        cycle();
        i_cnt_clr = 1'b0;
        check("cnt_clr0", 64'(o_bubble_cnt), 64'h0);
        i_flush = 1'b1;
        repeat (5) cycle();
        i_flush = 1'b0;
        i_halt = 1'b1;
        repeat (3) cycle();   // load edge, then two halted edges
        i_halt = 1'b0;
        cycle();              // third halted edge, returns to RUN
`ifdef ID_EX_BUBBLE_CNT_EN
        check("cnt_8", 64'(o_bubble_cnt), 64'd8);
`else
        check("cnt_off", 64'(o_bubble_cnt), 64'd0);
`endif
        i_cnt_clr = 1'b1;
        cycle();
        i_cnt_clr = 1'b0;
        check("cnt_clr", 64'(o_bubble_cnt), 64'h0);
        i_flush = 1'b1;
        repeat (15) cycle();
`ifdef ID_EX_BUBBLE_CNT_EN
        check("cnt_full", 64'(o_bubble_cnt), 64'hF);
`else
        check("cnt_full_off", 64'(o_bubble_cnt), 64'h0);
`endif
        repeat (2) cycle();
`ifdef ID_EX_BUBBLE_CNT_EN
        check("cnt_sat", 64'(o_bubble_cnt), 64'hF);
`else
        check("cnt_sat_off", 64'(o_bubble_cnt), 64'h0);
`endif
        i_flush = 1'b0;

        // Reset while halted returns to RUN with a bubble
        drive(20'h40001, 1'b1, 32'h0BAD_F00D);
        i_halt = 1'b1;
        cycle();
        cycle();
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_mid_halted",    64'(o_halted),        64'h0);
        check("rst_mid_stall_req", 64'(o_stall_req),     64'h0);
        check("rst_mid_valid",     64'(o_valid),         64'h0);
        check("rst_mid_ctrl",      64'(o_ctrl_register), 64'h0);
        i_halt = 1'b0;
        cycle();
        i_rst_n = 1'b1;
        drive(20'h0A5C3, 1'b1, 32'h1357_9BDF);
        cycle();
        check("post_rst_ctrl", 64'(o_ctrl_register), 64'h0A5C3);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
